// File: rtl/rggen_interrupt_sequencer_pkg.sv
// Shared types for the interrupt sequencer: the interrupt-line FSM state encoding.
package rggen_interrupt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;

endpackage

// File: rtl/rggen_interrupt_sequencer_if.sv
// Event/status/enable bundle between peripheral sources, the status field and the sequencer.
interface rggen_interrupt_sequencer_if #(
  parameter int WIDTH         = 1,
  parameter int HOLDOFF_WIDTH = 8
);

  logic [WIDTH-1:0]         i_event;
  logic [WIDTH-1:0]         i_status;
  logic [WIDTH-1:0]         i_enable;
  logic [HOLDOFF_WIDTH-1:0] i_holdoff;
  logic [WIDTH-1:0]         o_set;
  logic [WIDTH-1:0]         o_lost;
  logic                     o_irq;

  modport master (
    output i_event, i_status, i_enable, i_holdoff,
    input  o_set, o_lost, o_irq
  );

  modport slave (
    input  i_event, i_status, i_enable, i_holdoff,
    output o_set, o_lost, o_irq
  );

endinterface

// File: rtl/rggen_event_qualifier.sv
// Per-bit edge/level qualification of raw events into registered set and lost pulses.
module rggen_event_qualifier #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] EDGE_MODE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_event,
  input  logic [WIDTH-1:0] i_status,
  output logic [WIDTH-1:0] o_set,
  output logic [WIDTH-1:0] o_lost
);

  logic [WIDTH-1:0] event_q;
  logic [WIDTH-1:0] qual;
  logic [WIDTH-1:0] set_q;
  logic [WIDTH-1:0] lost_q;

  // Edge bits fire only on 0->1; level bits fire every cycle the source is high.
  assign qual = (EDGE_MODE & i_event & ~event_q) | (~EDGE_MODE & i_event);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      event_q <= '0;
      set_q   <= '0;
      lost_q  <= '0;
    end else begin
      event_q <= i_event;
      set_q   <= qual;
      lost_q  <= qual & i_status;
    end
  end

  assign o_set  = set_q;
  assign o_lost = lost_q;

endmodule

// File: rtl/rggen_interrupt_sequencer.sv
// Drives a W1C status field from event sources and produces a rate-limited interrupt line.
module rggen_interrupt_sequencer
  import rggen_interrupt_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter logic [WIDTH-1:0] EDGE_MODE     = '0,
  parameter int               HOLDOFF_WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  rggen_interrupt_sequencer_if.slave bus
);

  irq_state_e               state_q;
  irq_state_e               state_d;
  logic [HOLDOFF_WIDTH-1:0] cnt_q;
  logic [HOLDOFF_WIDTH-1:0] cnt_d;
  logic                     irq_q;
  logic                     pending;
  logic [WIDTH-1:0]         set;
  logic [WIDTH-1:0]         lost;

  rggen_event_qualifier #(
    .WIDTH     (WIDTH),
    .EDGE_MODE (EDGE_MODE)
  ) u_qualifier (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_event  (bus.i_event),
    .i_status (bus.i_status),
    .o_set    (set),
    .o_lost   (lost)
  );

  assign pending = |(bus.i_status & bus.i_enable);

  // Hold-off length is captured only when leaving ASSERT; later i_holdoff changes are ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pending) state_d = ASSERT;
      end
      ASSERT: begin
        if (!pending) begin
          if (bus.i_holdoff == '0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            cnt_d   = bus.i_holdoff - HOLDOFF_WIDTH'(1);
          end
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - HOLDOFF_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= (state_d == ASSERT);
    end
  end

  assign bus.o_set  = set;
  assign bus.o_lost = lost;
  assign bus.o_irq  = irq_q;

endmodule

// File: tb/tb_rggen_interrupt_sequencer.sv
// Cycle-by-cycle check of the interrupt sequencer against a timeline-based reference model.
module tb_rggen_interrupt_sequencer;

  localparam int         W     = 4;
  localparam int         HW    = 8;
  localparam logic [3:0] EMODE = 4'b0011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rggen_interrupt_sequencer_if #(.WIDTH(W), .HOLDOFF_WIDTH(HW)) bus ();

  rggen_interrupt_sequencer #(
    .WIDTH         (W),
    .EDGE_MODE     (EMODE),
    .HOLDOFF_WIDTH (HW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference model: the status field plus when the interrupt line is allowed to rise again.
  logic [3:0] statusM  = '0;
  logic [3:0] evPrevM  = '0;
  logic [3:0] expSet   = '0;
  logic [3:0] expLost  = '0;
  logic       asserted = 1'b0;
  int         blockedUntil = 0;
  int         cycle = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", tag, cycle, observed, expected);
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs after the edge.
  task automatic applyStimulus(input logic [3:0] ev, input logic [3:0] clr, input logic [3:0] en,
                               input logic [7:0] ho, input logic rstn);
    logic [3:0] qual, nSet, nLost, nEvPrev, nStatus;
    logic       pend, nAsserted;
    int         nBlocked;
    @(negedge clk);
    bus.i_event   = ev;
    bus.i_status  = statusM;
    bus.i_enable  = en;
    bus.i_holdoff = ho;
    rst_n         = rstn;

    qual      = (EMODE & ev & ~evPrevM) | (~EMODE & ev);
    pend      = |(statusM & en);
    nSet      = rstn ? qual : 4'h0;
    nLost     = rstn ? (qual & statusM) : 4'h0;
    nEvPrev   = rstn ? ev : 4'h0;
    nStatus   = (statusM & ~clr) | expSet;
    nAsserted = asserted;
    nBlocked  = blockedUntil;
    if (!rstn) begin
      nAsserted = 1'b0;
      nBlocked  = 0;
    end else if (asserted) begin
      if (!pend) begin
        nAsserted = 1'b0;
        nBlocked  = cycle + int'(ho) + 1;
      end
    end else if (cycle >= blockedUntil && pend) begin
      nAsserted = 1'b1;
    end

    @(posedge clk);
    #1;
    checkOutput("o_set",  32'(bus.o_set),  32'(nSet));
    checkOutput("o_lost", 32'(bus.o_lost), 32'(nLost));
    checkOutput("o_irq",  32'(bus.o_irq),  32'(nAsserted));

    expSet       = nSet;
    expLost      = nLost;
    evPrevM      = nEvPrev;
    statusM      = nStatus;
    asserted     = nAsserted;
    blockedUntil = nBlocked;
    cycle++;
  endtask

  task automatic idle(input int n, input logic [3:0] ev, input logic [3:0] en, input logic [7:0] ho);
    for (int i = 0; i < n; i++) applyStimulus(ev, 4'h0, en, ho, 1'b1);
  endtask

  initial begin
    bus.i_event   = '0;
    bus.i_status  = '0;
    bus.i_enable  = '0;
    bus.i_holdoff = '0;

    applyStimulus(4'h0, 4'h0, 4'hF, 8'd0, 1'b0);
    applyStimulus(4'h0, 4'h0, 4'hF, 8'd0, 1'b0);

    // Mixed edge/level bits held high for five cycles, no hold-off.
    idle(5, 4'hF, 4'hF, 8'd0);
    idle(4, 4'h0, 4'hF, 8'd0);
    applyStimulus(4'h0, 4'hF, 4'hF, 8'd0, 1'b1);
    idle(3, 4'h0, 4'hF, 8'd0);

    // Disabled bit latches in status without raising irq, then enable it.
    applyStimulus(4'h1, 4'h0, 4'h0, 8'd0, 1'b1);
    idle(4, 4'h0, 4'h0, 8'd0);
    idle(3, 4'h0, 4'h1, 8'd0);
    applyStimulus(4'h0, 4'hF, 4'h1, 8'd0, 1'b1);
    idle(2, 4'h0, 4'h1, 8'd0);

    // Hold-off of 5 with a re-fire one cycle after the clear.
    applyStimulus(4'h2, 4'h0, 4'hF, 8'd5, 1'b1);
    idle(3, 4'h0, 4'hF, 8'd5);
    applyStimulus(4'h0, 4'h2, 4'hF, 8'd5, 1'b1);
    applyStimulus(4'h2, 4'h0, 4'hF, 8'd5, 1'b1);
    idle(9, 4'h0, 4'hF, 8'd5);
    applyStimulus(4'h0, 4'hF, 4'hF, 8'd5, 1'b1);
    idle(8, 4'h0, 4'hF, 8'd0);

    // Level event on an already-set bit, then set/clear collision.
    idle(4, 4'h4, 4'hF, 8'd0);
    applyStimulus(4'h4, 4'h4, 4'hF, 8'd0, 1'b1);
    idle(2, 4'h4, 4'hF, 8'd0);
    applyStimulus(4'h0, 4'hF, 4'hF, 8'd0, 1'b1);
    idle(3, 4'h0, 4'hF, 8'd0);

    // Reset pulse during hold-off while an edge-mode source stays high.
    applyStimulus(4'h1, 4'h0, 4'hF, 8'd5, 1'b1);
    idle(3, 4'h1, 4'hF, 8'd5);
    applyStimulus(4'h1, 4'h1, 4'hF, 8'd5, 1'b1);
    idle(2, 4'h1, 4'hF, 8'd5);
    applyStimulus(4'h1, 4'h0, 4'hF, 8'd5, 1'b0);
    idle(4, 4'h1, 4'hF, 8'd5);
    applyStimulus(4'h0, 4'hF, 4'hF, 8'd5, 1'b1);
    idle(8, 4'h0, 4'hF, 8'd5);

    // Hold-off length changed mid hold-off must not shorten it.
    applyStimulus(4'h2, 4'h0, 4'hF, 8'd5, 1'b1);
    idle(3, 4'h0, 4'hF, 8'd5);
    applyStimulus(4'h0, 4'h2, 4'hF, 8'd5, 1'b1);
    applyStimulus(4'h2, 4'h0, 4'hF, 8'd5, 1'b1);
    idle(9, 4'h0, 4'hF, 8'd1);
    applyStimulus(4'h0, 4'hF, 4'hF, 8'd1, 1'b1);
    idle(8, 4'h0, 4'hF, 8'd0);

    for (int i = 0; i < 600; i++) begin
      logic [3:0] ev, clr, en;
      logic [7:0] ho;
      logic       rstn;
      ev   = 4'($urandom) & 4'($urandom);
      clr  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 7) == 0) clr = 4'hF;
      en   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      ho   = 8'($urandom_range(0, 6));
      rstn = ($urandom_range(0, 99) != 0);
      applyStimulus(ev, clr, en, ho, rstn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
